// File: rtl/demux_sync_sink_pkg.sv
// Shared types and helpers for the bundled-data demux sink.
package demux_sync_sink_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_ACK  = 1'b1
  } ch_state_t;

  localparam logic SEL_B0 = 1'b0;
  localparam logic SEL_B1 = 1'b1;

  // Ceiling log2, used to size FIFO pointers at elaboration time.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hs_sync_rx.sv
// One 4-phase receive channel: request synchroniser, IDLE/ACK FSM and ack flop.
module hs_sync_rx
  import demux_sync_sink_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic grant_i,
  output logic want_o,
  output logic ack_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  ch_state_t              state_q, state_d;
  logic                   ack_q, ack_d;
  logic                   rs;

  assign rs    = sync_q[SYNC_STAGES-1];
  assign ack_o = ack_q;

  // Request synchroniser chain; rs is the last flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
  end

  // Channel state and acknowledge registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CH_IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  // Ask for a push only while idle; ack goes high on the push edge and
  // drops once the synchronised request has returned to zero.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    want_o  = 1'b0;
    case (state_q)
      CH_IDLE: begin
        want_o = rs;
        if (rs && grant_i) begin
          state_d = CH_ACK;
          ack_d   = 1'b1;
        end
      end
      CH_ACK: begin
        if (!rs) begin
          state_d = CH_IDLE;
          ack_d   = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: rtl/demux_sync_sink.sv
// Clocked sink for the two demux branches: sync, capture, tag and queue words.
module demux_sync_sink
  import demux_sync_sink_pkg::*;
#(
  parameter int N           = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r0_i,
  output logic         a0_o,
  input  logic [N-1:0] d0_i,
  input  logic         r1_i,
  output logic         a1_o,
  input  logic [N-1:0] d1_i,
  output logic         v_o,
  input  logic         rdy_i,
  output logic [N-1:0] d_o,
  output logic         sel_o
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          want0, want1, grant0, grant1;
  logic          full, push, pop;
  logic [N:0]    push_word, head, last_q;
  logic [N:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  hs_sync_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx0 (
    .clk(clk), .rst(rst), .req_i(r0_i), .grant_i(grant0), .want_o(want0), .ack_o(a0_o)
  );

  hs_sync_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx1 (
    .clk(clk), .rst(rst), .req_i(r1_i), .grant_i(grant1), .want_o(want1), .ack_o(a1_o)
  );

  // Full is judged on the registered count only, so a same-cycle pop never
  // opens space for a push. Branch 0 wins a tie.
  assign full      = (cnt_q == CW'(DEPTH));
  assign grant0    = want0 && !full;
  assign grant1    = want1 && !want0 && !full;
  assign push      = grant0 || grant1;
  assign push_word = grant0 ? {SEL_B0, d0_i} : {SEL_B1, d1_i};

  assign v_o  = (cnt_q != '0);
  assign pop  = v_o && rdy_i;
  assign head = mem_q[rptr_q];

  // When empty, show the last word popped (zero after reset).
  assign {sel_o, d_o} = v_o ? head : last_q;

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  // FIFO pointers and count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage: capture the tagged word on the push edge; data bypasses the
  // synchroniser because bundling keeps it stable well before rs rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= push_word;
    end
  end

  // Remember the word being popped so the output holds it once empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     last_q <= '0;
    else if (pop) last_q <= head;
  end

endmodule

// File: tb/tb_demux_sync_sink.sv
// Self-checking bench for demux_sync_sink: vector table, scoreboard, corner sequences.
module tb_demux_sync_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_i, r1_i, a0_o, a1_o, v_o, rdy_i, sel_o;
  logic [31:0] d0_i, d1_i, d_o;
  logic        rdy_man, rnd_rdy, rnd_on;

  int checks = 0;
  int fails  = 0;

  logic [32:0] exp_q[$];

  typedef struct {
    bit          br;
    logic [31:0] d;
    bit          exp_sel;
    logic [31:0] exp_d;
  } vec_t;
  vec_t vecs [6];

  assign rdy_i = rnd_on ? rnd_rdy : rdy_man;

  always #5 clk = ~clk;

  demux_sync_sink #(.N(32), .SYNC_STAGES(2), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .r0_i(r0_i), .a0_o(a0_o), .d0_i(d0_i),
    .r1_i(r1_i), .a1_o(a1_o), .d1_i(d1_i),
    .v_o(v_o), .rdy_i(rdy_i), .d_o(d_o), .sel_o(sel_o)
  );

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Scoreboard plus an independent occupancy model built from ack rises
  // (pushes) and observed pops; sampled on the falling edge.
  int          mcount = 0;
  bit          pa0 = 0, pa1 = 0, popp = 0, prev_hold = 0;
  logic [32:0] prev_out = '0;
  logic [32:0] e;
  always @(negedge clk) begin
    if (!rst) begin
      mcount = 0; pa0 = 0; pa1 = 0; popp = 0; prev_hold = 0;
    end else begin
      mcount = mcount + int'(a0_o && !pa0) + int'(a1_o && !pa1) - int'(popp);
      pa0 = a0_o;
      pa1 = a1_o;
      chk("occupancy_le_depth", 33'(mcount <= 2), 33'(1));
      chk("v_vs_model", 33'(v_o), 33'(mcount != 0));
      if (prev_hold && v_o) chk("hold_stable", {sel_o, d_o}, prev_out);
      if (v_o && rdy_i) begin
        if (exp_q.size() == 0) chk("unexpected_output", {sel_o, d_o}, 33'h1_DEAD_BEEF ^ {sel_o, d_o} ^ 33'h1_DEAD_BEEF ^ 33'h1);
        else begin
          e = exp_q.pop_front();
          chk("stream_word", {sel_o, d_o}, e);
        end
        popp = 1;
      end else popp = 0;
      prev_hold = v_o && !rdy_i;
      prev_out  = {sel_o, d_o};
    end
  end

  always @(posedge clk) begin
    #1 rnd_rdy = 1'($urandom_range(0, 1));
  end

  task automatic wait_ack(input bit br, input bit lvl, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk); #1;
      if ((br ? a1_o : a0_o) == lvl) hit = 1;
    end
    chk(lvl ? "ack_rise_timeout" : "ack_fall_timeout", 33'(hit), 33'(1));
  endtask

  task automatic tok(input bit br, input logic [31:0] d);
    @(posedge clk); #1;
    if (br) begin d1_i = d; r1_i = 1'b1; end
    else    begin d0_i = d; r0_i = 1'b1; end
    exp_q.push_back({br, d});
    wait_ack(br, 1'b1, 200);
    if (br) r1_i = 1'b0; else r0_i = 1'b0;
    wait_ack(br, 1'b0, 20);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || v_o); i++) begin
      @(posedge clk); #1;
    end
    chk("drain_queue_empty", 33'(exp_q.size()), 33'(0));
    chk("drain_v_low", 33'(v_o), 33'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0011, 1'b0, 32'h0000_0011};
    vecs[1] = '{1'b1, 32'h0000_0022, 1'b1, 32'h0000_0022};
    vecs[2] = '{1'b0, 32'h0000_0033, 1'b0, 32'h0000_0033};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
    vecs[4] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[5] = '{1'b1, 32'h8000_0001, 1'b1, 32'h8000_0001};

    rst = 1'b0; r0_i = 0; r1_i = 0; d0_i = '0; d1_i = '0;
    rdy_man = 1'b0; rnd_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a0", 33'(a0_o), 33'(0));
    chk("rst_a1", 33'(a1_o), 33'(0));
    chk("rst_v", 33'(v_o), 33'(0));
    chk("rst_d", 33'(d_o), 33'(0));
    chk("rst_sel", 33'(sel_o), 33'(0));
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Single branch-0 token with latency checks.
    @(posedge clk); #1;
    rdy_man = 1'b1; d0_i = 32'hA5A5_0001; r0_i = 1'b1;
    exp_q.push_back({1'b0, 32'hA5A5_0001});
    repeat (2) @(posedge clk); #1;
    chk("a0_not_early", 33'(a0_o), 33'(0));
    @(posedge clk); #1;
    chk("a0_rise_lat", 33'(a0_o), 33'(1));
    chk("v_after_push", 33'(v_o), 33'(1));
    chk("d_after_push", {sel_o, d_o}, {1'b0, 32'hA5A5_0001});
    r0_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("a0_still_high", 33'(a0_o), 33'(1));
    @(posedge clk); #1;
    chk("a0_fall_lat", 33'(a0_o), 33'(0));
    drain();

    // Table of tokens with ready held high.
    for (int i = 0; i < 6; i++) begin
      rdy_man = 1'b1;
      @(posedge clk); #1;
      if (vecs[i].br) begin d1_i = vecs[i].d; r1_i = 1'b1; end
      else            begin d0_i = vecs[i].d; r0_i = 1'b1; end
      exp_q.push_back({vecs[i].exp_sel, vecs[i].exp_d});
      wait_ack(vecs[i].br, 1'b1, 50);
      r0_i = 1'b0; r1_i = 1'b0;
      wait_ack(vecs[i].br, 1'b0, 20);
    end
    drain();

    // Back-pressure: two fill the FIFO, third is held unacked.
    rdy_man = 1'b0;
    tok(1'b1, 32'h1);
    tok(1'b1, 32'h2);
    @(posedge clk); #1;
    d1_i = 32'h3; r1_i = 1'b1;
    exp_q.push_back({1'b1, 32'h3});
    repeat (8) @(posedge clk); #1;
    chk("full_holds_ack", 33'(a1_o), 33'(0));
    chk("full_v", 33'(v_o), 33'(1));
    chk("full_head", {sel_o, d_o}, {1'b1, 32'h1});
    rdy_man = 1'b1;
    wait_ack(1'b1, 1'b1, 20);
    r1_i = 1'b0;
    wait_ack(1'b1, 1'b0, 20);
    drain();

    // Both requests in the same cycle: branch 0 first, branch 1 next edge.
    @(posedge clk); #1;
    d0_i = 32'hAA; d1_i = 32'hBB; r0_i = 1'b1; r1_i = 1'b1;
    exp_q.push_back({1'b0, 32'hAA});
    exp_q.push_back({1'b1, 32'hBB});
    repeat (3) @(posedge clk); #1;
    chk("tie_a0_first", 33'(a0_o), 33'(1));
    chk("tie_a1_waits", 33'(a1_o), 33'(0));
    @(posedge clk); #1;
    chk("tie_a1_next", 33'(a1_o), 33'(1));
    r0_i = 1'b0; r1_i = 1'b0;
    wait_ack(1'b0, 1'b0, 20);
    wait_ack(1'b1, 1'b0, 20);
    drain();

    // Reset in the middle of a branch-1 handshake.
    rdy_man = 1'b0;
    @(posedge clk); #1;
    d1_i = 32'h55; r1_i = 1'b1;
    exp_q.push_back({1'b1, 32'h55});
    wait_ack(1'b1, 1'b1, 20);
    #2 rst = 1'b0;
    #1;
    chk("midrst_a1", 33'(a1_o), 33'(0));
    chk("midrst_v", 33'(v_o), 33'(0));
    chk("midrst_d", {sel_o, d_o}, 33'(0));
    exp_q.delete();
    r1_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rdy_man = 1'b1;
    tok(1'b0, 32'h77);
    drain();

    // Wrap-around with random ready.
    rnd_on = 1'b1;
    for (int i = 0; i < 10; i++) tok(1'(i % 2), 32'(i));
    rnd_on = 1'b0;
    rdy_man = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
